motor_uart_rx: RTL and testbench

Serial-command receiver for the motor link: the receiving end of the 8N1 UART stream that `drive_motor` emits on `GPIO[5]`. It deserialises bytes and decodes them as two-channel simplified-serial motor commands. A watchdog forces both channels to stop when the link goes quiet. The block runs on the `CLOCK_50` domain and serves as the loopback checker for the drive path and as the command front-end for a second-board motor controller.

---
 rtl/motor_uart_rx.sv | 185 ++++++++++++++++++
 tb/tb_motor_uart_rx.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/motor_uart_rx.sv
`timescale 1ns/1ps
// motor_uart_rx
// Receives the 8N1 serial motor-command stream and decodes each byte into two
// 7-bit motor levels. A watchdog forces both channels to stop when the link
// goes quiet.
//
// Handshake: rx_valid is a one-cycle qualifier with no backpressure. rx_byte,
// m1_cmd and m2_cmd change on the same edge that raises rx_valid and hold
// until the next accepted byte. frame_err is a one-cycle event pulse.
//
// Ports:
//   CLOCK_50      in   sole clock, rising edge
//   reset         in   asynchronous, active-high
//   uart_in       in   serial line, idle high, asynchronous to CLOCK_50
//   rx_byte       out  last correctly framed byte
//   rx_valid      out  one-cycle pulse when rx_byte updates
//   frame_err     out  one-cycle pulse when the stop bit is sampled low
//   m1_cmd        out  motor-1 level (1 = full reverse, 64 = stop, 127 = full fwd)
//   m2_cmd        out  motor-2 level, same scale
//   link_timeout  out  high while the watchdog has expired
//   dbg_state     out  current receiver FSM state (IDLE=0 .. WAIT_IDLE=4)
module motor_uart_rx #(
  parameter int CLK_FREQ       = 50_000_000,
  parameter int BAUD           = 9600,
  parameter int TIMEOUT_CYCLES = 25_000_000
) (
  input  logic       CLOCK_50,
  input  logic       reset,
  input  logic       uart_in,
  output logic [7:0] rx_byte,
  output logic       rx_valid,
  output logic       frame_err,
  output logic [6:0] m1_cmd,
  output logic [6:0] m2_cmd,
  output logic       link_timeout,
  output logic [2:0] dbg_state
);

  localparam int CLKS_PER_BIT = CLK_FREQ / BAUD;
  localparam int CW = $clog2(CLKS_PER_BIT + 1);
  localparam int WW = $clog2(TIMEOUT_CYCLES + 1);

  localparam logic [CW-1:0] HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] CNT_ONE   = CW'(1);
  localparam logic [WW-1:0] WD_LAST   = WW'(TIMEOUT_CYCLES - 1);
  localparam logic [WW-1:0] WD_MAX    = WW'(TIMEOUT_CYCLES);
  localparam logic [WW-1:0] WD_ONE    = WW'(1);
  localparam logic [6:0]    CMD_STOP  = 7'd64;

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_START     = 3'd1,
    S_DATA      = 3'd2,
    S_STOP      = 3'd3,
    S_WAIT_IDLE = 3'd4
  } state_t;

  // Two-flop synchroniser; resets to the idle-high line level.
  logic [1:0] sync_q;
  logic       rx_s;

  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) sync_q <= 2'b11;
    else       sync_q <= {sync_q[0], uart_in};
  end

  assign rx_s = sync_q[1];

  state_t        state, state_n;
  logic [CW-1:0] cnt, cnt_n;
  logic [2:0]    idx, idx_n;
  logic [7:0]    shift, shift_n;
  logic          byte_done;
  logic          ferr_n;
  logic [WW-1:0] wd_cnt;

  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      state <= S_IDLE;
      cnt   <= '0;
      idx   <= '0;
      shift <= '0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
      idx   <= idx_n;
      shift <= shift_n;
    end
  end

  always_comb begin
    state_n   = state;
    cnt_n     = cnt + CNT_ONE;
    idx_n     = idx;
    shift_n   = shift;
    byte_done = 1'b0;
    ferr_n    = 1'b0;
    case (state)
      S_IDLE: begin
        cnt_n = '0;
        idx_n = '0;
        if (!rx_s) state_n = S_START;
      end
      S_START: begin
        // Half a bit in: a line that has gone high again was only a glitch.
        if (cnt == HALF_LAST) begin
          cnt_n   = '0;
          state_n = rx_s ? S_IDLE : S_DATA;
        end
      end
      S_DATA: begin
        if (cnt == BIT_LAST) begin
          cnt_n   = '0;
          shift_n = {rx_s, shift[7:1]};  // LSB arrives first
          idx_n   = idx + 3'd1;
          if (idx == 3'd7) state_n = S_STOP;
        end
      end
      S_STOP: begin
        // Completing at mid-stop leaves half a bit of slack before the next
        // start edge, so back-to-back frames are not lost.
        if (cnt == BIT_LAST) begin
          cnt_n = '0;
          if (rx_s) begin
            byte_done = 1'b1;
            state_n   = S_IDLE;
          end else begin
            ferr_n  = 1'b1;
            state_n = S_WAIT_IDLE;
          end
        end
      end
      S_WAIT_IDLE: begin
        // A held-low line (break) must not be mistaken for new start bits.
        cnt_n = '0;
        if (rx_s) state_n = S_IDLE;
      end
      default: begin
        cnt_n   = '0;
        state_n = S_IDLE;
      end
    endcase
  end

  assign dbg_state = state;

  // Output registers, command decode and watchdog. An accepted byte always
  // takes priority over the watchdog expiring on the same edge.
  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      rx_byte      <= '0;
      rx_valid     <= 1'b0;
      frame_err    <= 1'b0;
      m1_cmd       <= CMD_STOP;
      m2_cmd       <= CMD_STOP;
      link_timeout <= 1'b0;
      wd_cnt       <= '0;
    end else begin
      rx_valid  <= byte_done;
      frame_err <= ferr_n;
      if (byte_done) begin
        rx_byte      <= shift;
        wd_cnt       <= '0;
        link_timeout <= 1'b0;
        if (shift == 8'h00) begin
          m1_cmd <= CMD_STOP;
          m2_cmd <= CMD_STOP;
        end else if (!shift[7]) begin
          m1_cmd <= shift[6:0];
        end else begin
          m2_cmd <= shift[6:0];
        end
      end else begin
        if (wd_cnt != WD_MAX) wd_cnt <= wd_cnt + WD_ONE;
        if (wd_cnt == WD_LAST) begin
          link_timeout <= 1'b1;
          m1_cmd       <= CMD_STOP;
          m2_cmd       <= CMD_STOP;
        end
      end
    end
  end

endmodule

// File: tb/tb_motor_uart_rx.sv
`timescale 1ns/1ps
// Testbench for motor_uart_rx at 16 clocks per bit and a 2000-cycle watchdog.
module tb_motor_uart_rx;

  localparam int  CLK_FREQ = 50_000_000;
  localparam int  BAUD     = 3_125_000;
  localparam int  TIMEOUT  = 2000;
  localparam real BIT_NS   = 320.0;

  // ---------------- clock / reset ----------------
  logic       clk = 1'b0;
  logic       rst;
  logic       uart_in;
  logic [7:0] rx_byte;
  logic       rx_valid;
  logic       frame_err;
  logic [6:0] m1_cmd;
  logic [6:0] m2_cmd;
  logic       link_timeout;
  logic [2:0] dbg_state;

  always #10 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  motor_uart_rx #(
    .CLK_FREQ(CLK_FREQ), .BAUD(BAUD), .TIMEOUT_CYCLES(TIMEOUT)
  ) dut (
    .CLOCK_50(clk), .reset(rst), .uart_in(uart_in),
    .rx_byte(rx_byte), .rx_valid(rx_valid), .frame_err(frame_err),
    .m1_cmd(m1_cmd), .m2_cmd(m2_cmd), .link_timeout(link_timeout),
    .dbg_state(dbg_state)
  );

  // ---------------- scoreboard state ----------------
  int checks   = 0;
  int failures = 0;
  logic [21:0] exp_q[$];   // {byte, m1, m2} expected at each rx_valid
  logic [21:0] exp_e;
  int exp_ferr = 0;
  int got_ferr = 0;
  int last_vc  = 0;
  logic [6:0] mod_m1 = 7'd64;
  logic [6:0] mod_m2 = 7'd64;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", name, got, exp);
    end
  endtask

  // Reference command model: applies one received byte to the two channels.
  task automatic expect_byte(input logic [7:0] b);
    if (b == 8'h00) begin
      mod_m1 = 7'd64;
      mod_m2 = 7'd64;
    end else if (b < 8'h80) begin
      mod_m1 = b[6:0];
    end else begin
      mod_m2 = b - 8'h80;
    end
    exp_q.push_back({b, mod_m1, mod_m2});
  endtask

  // ---------------- monitor ----------------
  always @(negedge clk) begin
    if (!rst) begin
      if (rx_valid) begin
        last_vc = cyc;
        check("timeout_on_valid", link_timeout, 0);
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_rx_valid got=%0h exp=none", rx_byte);
        end else begin
          exp_e = exp_q.pop_front();
          check("rx_frame", {rx_byte, m1_cmd, m2_cmd}, exp_e);
        end
      end
      if (frame_err) got_ferr++;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic send_frame(input logic [7:0] b, input logic stop_bit, input real bit_ns);
    uart_in = 1'b0;
    #(bit_ns);
    for (int i = 0; i < 8; i++) begin
      uart_in = b[i];
      #(bit_ns);
    end
    uart_in = stop_bit;
    #(bit_ns);
  endtask

  task automatic send_good(input logic [7:0] b, input real bit_ns);
    expect_byte(b);
    send_frame(b, 1'b1, bit_ns);
  endtask

  task automatic drain(input string name);
    for (int i = 0; i < 600 && exp_q.size() != 0; i++) @(negedge clk);
    check(name, exp_q.size(), 0);
    exp_q.delete();
  endtask

  task automatic idle_cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  function automatic real pick_bit_ns();
    case ($urandom_range(0, 2))
      0:       return 314.0;
      1:       return 326.0;
      default: return BIT_NS;
    endcase
  endfunction

  // Absolute time bound for the whole run.
  initial begin
    #5ms;
    $display("FAIL sim_time_limit got=expired exp=finished");
    $fatal(1, "simulation time limit");
  end

  // ---------------- stimulus ----------------
  logic [7:0] rb;

  initial begin
    rst = 1'b1;
    uart_in = 1'b1;
    idle_cycles(5);
    rst = 1'b0;

    // Reset values and quiet idle line
    idle_cycles(100);
    check("rst_m1", m1_cmd, 64);
    check("rst_m2", m2_cmd, 64);
    check("rst_byte", rx_byte, 0);
    check("rst_timeout", link_timeout, 0);
    check("rst_state", dbg_state, 0);

    // Back-to-back channel-1 / channel-2 commands
    send_good(8'h7F, BIT_NS);
    send_good(8'hC0, BIT_NS);
    send_good(8'h01, BIT_NS);
    drain("drain_b2b");
    check("b2b_m1", m1_cmd, 1);
    check("b2b_m2", m2_cmd, 64);

    // Full-forward channel 2, then all-stop
    send_good(8'hFF, BIT_NS);
    drain("drain_ff");
    check("ff_m2", m2_cmd, 127);
    send_good(8'h00, BIT_NS);
    drain("drain_00");
    check("stop_m1", m1_cmd, 64);
    check("stop_m2", m2_cmd, 64);

    // Framing error followed by a held-low line
    exp_ferr++;
    send_frame(8'hA5, 1'b0, BIT_NS);
    #(40 * 20);
    uart_in = 1'b1;
    #(BIT_NS);
    check("ferr_count", got_ferr, exp_ferr);
    check("ferr_m1_kept", m1_cmd, mod_m1);
    check("ferr_m2_kept", m2_cmd, mod_m2);
    send_good(8'h40, BIT_NS);
    drain("drain_after_ferr");
    check("after_ferr_m1", m1_cmd, 64);

    // Short low glitch on an idle line
    uart_in = 1'b0;
    idle_cycles(5);
    uart_in = 1'b1;
    idle_cycles(30);
    check("glitch_state", dbg_state, 0);
    check("glitch_ferr", got_ferr, exp_ferr);

    // Random bytes at nominal and +/-2% bit periods, with random gaps
    for (int n = 0; n < 24; n++) begin
      rb = 8'($urandom_range(0, 255));
      send_good(rb, pick_bit_ns());
      if ($urandom_range(0, 3) == 0) #(BIT_NS * $urandom_range(1, 3));
    end
    drain("drain_random");
    check("rand_m1", m1_cmd, mod_m1);
    check("rand_m2", m2_cmd, mod_m2);

    // Watchdog expiry around the boundary, then recovery
    send_good(8'h10, BIT_NS);
    drain("drain_0x10");
    while (cyc - last_vc < TIMEOUT - 2) @(negedge clk);
    check("wd_before", link_timeout, 0);
    check("wd_before_m1", m1_cmd, 16);
    while (cyc - last_vc < TIMEOUT + 2) @(negedge clk);
    check("wd_after", link_timeout, 1);
    check("wd_after_m1", m1_cmd, 64);
    check("wd_after_m2", m2_cmd, 64);
    mod_m1 = 7'd64;
    mod_m2 = 7'd64;
    send_good(8'h30, BIT_NS);
    drain("drain_0x30");
    check("wd_clear", link_timeout, 0);
    check("wd_clear_m1", m1_cmd, 48);

    // Reset during data bit 4 of a frame
    rb = 8'h5A;
    uart_in = 1'b0;
    #(BIT_NS);
    for (int i = 0; i < 4; i++) begin
      uart_in = rb[i];
      #(BIT_NS);
    end
    uart_in = rb[4];
    #(BIT_NS / 2);
    rst = 1'b1;
    #60;
    uart_in = 1'b1;
    #100;
    @(negedge clk);
    rst = 1'b0;
    mod_m1 = 7'd64;
    mod_m2 = 7'd64;
    exp_q.delete();
    @(negedge clk);
    check("mid_rst_byte", rx_byte, 0);
    check("mid_rst_m1", m1_cmd, 64);
    check("mid_rst_m2", m2_cmd, 64);
    check("mid_rst_timeout", link_timeout, 0);
    check("mid_rst_state", dbg_state, 0);
    send_good(8'h20, BIT_NS);
    drain("drain_0x20");
    check("post_rst_m1", m1_cmd, 32);

    idle_cycles(20);
    check("final_ferr", got_ferr, exp_ferr);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
